seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with tear-free double-buffered digit data.
// Optional blink support is compiled in when SEG_SCAN_BLINK_EN is defined.
module seg_scan_ctrl #(
   parameter int unsigned DIGITS       = 8,
   parameter int unsigned DIV          = 1024,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [4*DIGITS-1:0]          hexs,
   input  logic [DIGITS-1:0]            point,
   input  logic [DIGITS-1:0]            les,
   input  logic [DIGITS-1:0]            blank,
`ifdef SEG_SCAN_BLINK_EN
   input  logic [DIGITS-1:0]            blink,
`endif
   input  logic                         load,
   output logic                         load_ack,
   output logic [3:0]                   hexo,
   output logic [DIGITS-1:0]            an,
   output logic                         p,
   output logic                         le,
   output logic [$clog2(DIGITS)-1:0]    scan,
   output logic                         frame
);

   localparam int unsigned SW = $clog2(DIGITS);
   localparam int unsigned CW = $clog2(DIV);
   localparam int unsigned HW = 4 * DIGITS;

   if (DIGITS < 2 || DIGITS > 16 || DIV < 4 || BLINK_FRAMES < 1) begin : g_bad_param
      $error("seg_scan_ctrl: illegal parameter value");
   end

   logic [CW-1:0]     pcnt, pcnt_nx;
   logic              tick, wrap;

   logic [HW-1:0]     act_hex, act_hex_nx, pnd_hex, pnd_hex_nx;
   logic [DIGITS-1:0] act_pt, act_pt_nx, pnd_pt, pnd_pt_nx;
   logic [DIGITS-1:0] act_le, act_le_nx, pnd_le, pnd_le_nx;
   logic [DIGITS-1:0] act_blank, act_blank_nx, pnd_blank, pnd_blank_nx;
   logic              pnd_vld, pnd_vld_nx;

   logic [SW-1:0]     scan_nx;
   logic [3:0]        hexo_nx;
   logic              p_nx, le_nx, ack_nx;
   logic [DIGITS-1:0] an_nx;
   logic [DIGITS-1:0] hide_c;

`ifdef SEG_SCAN_BLINK_EN
   localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [DIGITS-1:0] act_blink, act_blink_nx, pnd_blink, pnd_blink_nx;
   logic [FW-1:0]     fcnt, fcnt_nx;
   logic              phase, phase_nx;
`endif

   assign tick = (pcnt == CW'(DIV - 1));
   assign wrap = tick && (scan == SW'(DIGITS - 1));

   // next-state: prescaler, buffers, scan index and registered digit outputs
   always_comb begin
      pcnt_nx      = tick ? '0 : pcnt + CW'(1);
      act_hex_nx   = act_hex;
      act_pt_nx    = act_pt;
      act_le_nx    = act_le;
      act_blank_nx = act_blank;
      pnd_hex_nx   = pnd_hex;
      pnd_pt_nx    = pnd_pt;
      pnd_le_nx    = pnd_le;
      pnd_blank_nx = pnd_blank;
      pnd_vld_nx   = pnd_vld;
      ack_nx       = 1'b0;
      hide_c       = '0;
`ifdef SEG_SCAN_BLINK_EN
      act_blink_nx = act_blink;
      pnd_blink_nx = pnd_blink;
      fcnt_nx      = fcnt;
      phase_nx     = phase;
      if (phase) begin
         hide_c = act_blink;
      end
`endif

      // Commit only at the frame wrap; a load on that very cycle bypasses the pending buffer.
      if (wrap) begin
         pnd_vld_nx = 1'b0;
         if (load) begin
            act_hex_nx   = hexs;
            act_pt_nx    = point;
            act_le_nx    = les;
            act_blank_nx = blank;
`ifdef SEG_SCAN_BLINK_EN
            act_blink_nx = blink;
`endif
            ack_nx       = 1'b1;
         end else if (pnd_vld) begin
            act_hex_nx   = pnd_hex;
            act_pt_nx    = pnd_pt;
            act_le_nx    = pnd_le;
            act_blank_nx = pnd_blank;
`ifdef SEG_SCAN_BLINK_EN
            act_blink_nx = pnd_blink;
`endif
            ack_nx       = 1'b1;
         end
      end else if (load) begin
         pnd_hex_nx   = hexs;
         pnd_pt_nx    = point;
         pnd_le_nx    = les;
         pnd_blank_nx = blank;
`ifdef SEG_SCAN_BLINK_EN
         pnd_blink_nx = blink;
`endif
         pnd_vld_nx   = 1'b1;
      end

`ifdef SEG_SCAN_BLINK_EN
      if (wrap) begin
         if (fcnt == FW'(BLINK_FRAMES - 1)) begin
            fcnt_nx  = '0;
            phase_nx = ~phase;
         end else begin
            fcnt_nx = fcnt + FW'(1);
         end
      end
`endif

      scan_nx = scan;
      if (tick) begin
         scan_nx = wrap ? '0 : scan + SW'(1);
      end

      hexo_nx = '0;
      p_nx    = 1'b0;
      le_nx   = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (scan_nx == SW'(i)) begin
            hexo_nx = act_hex_nx[4*i +: 4];
            p_nx    = act_pt_nx[i];
            le_nx   = act_le_nx[i];
         end
      end

      // Anodes stay off for the first cycle of each slot to avoid ghosting.
      an_nx = '1;
      if (!tick) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (scan == SW'(i) && !act_blank[i] && !hide_c[i]) begin
               an_nx[i] = 1'b0;
            end
         end
      end
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt      <= '0;
         scan      <= '0;
         act_hex   <= '0;
         act_pt    <= '0;
         act_le    <= '0;
         act_blank <= '0;
         pnd_hex   <= '0;
         pnd_pt    <= '0;
         pnd_le    <= '0;
         pnd_blank <= '0;
         pnd_vld   <= 1'b0;
         hexo      <= '0;
         p         <= 1'b0;
         le        <= 1'b0;
         an        <= '1;
         frame     <= 1'b0;
         load_ack  <= 1'b0;
`ifdef SEG_SCAN_BLINK_EN
         act_blink <= '0;
         pnd_blink <= '0;
         fcnt      <= '0;
         phase     <= 1'b0;
`endif
      end else begin
         pcnt      <= pcnt_nx;
         scan      <= scan_nx;
         act_hex   <= act_hex_nx;
         act_pt    <= act_pt_nx;
         act_le    <= act_le_nx;
         act_blank <= act_blank_nx;
         pnd_hex   <= pnd_hex_nx;
         pnd_pt    <= pnd_pt_nx;
         pnd_le    <= pnd_le_nx;
         pnd_blank <= pnd_blank_nx;
         pnd_vld   <= pnd_vld_nx;
         hexo      <= hexo_nx;
         p         <= p_nx;
         le        <= le_nx;
         an        <= an_nx;
         frame     <= wrap;
         load_ack  <= ack_nx;
`ifdef SEG_SCAN_BLINK_EN
         act_blink <= act_blink_nx;
         pnd_blink <= pnd_blink_nx;
         fcnt      <= fcnt_nx;
         phase     <= phase_nx;
`endif
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGITS=4, DIV=4, BLINK_FRAMES=2).
// Expected outputs come from elapsed-cycle arithmetic plus a per-frame display buffer.
module tb_seg_scan_ctrl;

   localparam int D  = 4;
   localparam int DV = 4;
   localparam int BF = 2;
   localparam int FR = D * DV;
`ifdef SEG_SCAN_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] hexs = '0;
   logic [3:0]  point = '0, les = '0, blank = '0, blink = '0;
   logic        load = 1'b0;
   logic        load_ack, p, le, frame;
   logic [3:0]  hexo, an;
   logic [1:0]  scan;

   int n_cmp = 0;
   int n_fail = 0;
   bit started = 1'b0;

   // model state: cycles since reset release, displayed data, pending load
   int          mt = 0;
   logic [15:0] m_hex = '0, q_hex = '0;
   logic [3:0]  m_pt = '0, m_le = '0, m_bl = '0, m_bk = '0;
   logic [3:0]  q_pt = '0, q_le = '0, q_bl = '0, q_bk = '0;
   bit          q_vld = 1'b0, m_ack = 1'b0, m_frame = 1'b0;

   int          c_s, c_off, c_ph;
   logic [3:0]  c_ea;

   seg_scan_ctrl #(.DIGITS(D), .DIV(DV), .BLINK_FRAMES(BF)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .hexs     (hexs),
      .point    (point),
      .les      (les),
      .blank    (blank),
`ifdef SEG_SCAN_BLINK_EN
      .blink    (blink),
`endif
      .load     (load),
      .load_ack (load_ack),
      .hexo     (hexo),
      .an       (an),
      .p        (p),
      .le       (le),
      .scan     (scan),
      .frame    (frame)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0d: got %0h, expected %0h", nm, mt, act, exp);
      end
   endtask

   // Loads sampled within a frame are shown from the next frame on; the last one wins.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mt = 0; q_vld = 1'b0; m_ack = 1'b0; m_frame = 1'b0;
         m_hex = '0; m_pt = '0; m_le = '0; m_bl = '0; m_bk = '0;
      end else begin
         mt++;
         if (load) begin
            q_hex = hexs; q_pt = point; q_le = les; q_bl = blank; q_bk = blink;
            q_vld = 1'b1;
         end
         m_frame = (mt % FR == 0);
         m_ack   = 1'b0;
         if (m_frame && q_vld) begin
            m_hex = q_hex; m_pt = q_pt; m_le = q_le; m_bl = q_bl; m_bk = q_bk;
            m_ack = 1'b1;
            q_vld = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         c_s   = (mt / DV) % D;
         c_off = mt % DV;
         c_ph  = ((mt / FR) / BF) % 2;
         if (c_off == 0 || m_bl[c_s] || (BLINK_ON && c_ph == 1 && m_bk[c_s]))
            c_ea = 4'hF;
         else
            c_ea = ~(4'b0001 << c_s);
         chk("scan", 32'(scan), 32'(c_s));
         chk("hexo", 32'(hexo), 32'(m_hex[4*c_s +: 4]));
         chk("p", 32'(p), 32'(m_pt[c_s]));
         chk("le", 32'(le), 32'(m_le[c_s]));
         chk("an", 32'(an), 32'(c_ea));
         chk("frame", 32'(frame), 32'(m_frame));
         chk("load_ack", 32'(load_ack), 32'(m_ack));
      end
   end

   task automatic wait_t(input int tgt);
      int g = 0;
      while (mt != tgt && g < 500) begin
         @(posedge clk); #1;
         g++;
      end
      if (mt != tgt) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_t: reached t=%0d, required t=%0d", mt, tgt);
      end
   endtask

   task automatic do_load(input logic [15:0] h, input logic [3:0] pt, input logic [3:0] ls,
                          input logic [3:0] bl, input logic [3:0] bk);
      hexs = h; point = pt; les = ls; blank = bl; blink = bk;
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      started = 1'b1;
      @(negedge clk); #1;
      rst_n = 1'b1;
      #3;
      chk("lit_reset_an", 32'(an), 32'h0000000F);
      chk("lit_reset_scan", 32'(scan), 32'h0);

      wait_t(1);  chk("lit_an_slot0", 32'(an), 32'hE);
      wait_t(5);  chk("lit_an_slot1", 32'(an), 32'hD);
      wait_t(16); chk("lit_frame0", 32'(frame), 32'h1);
      chk("lit_noack0", 32'(load_ack), 32'h0);

      // load mid-frame at scan 1
      wait_t(20); do_load(16'h4321, 4'h0, 4'h0, 4'h0, 4'h0);
      wait_t(24); chk("lit_hold_old", 32'(hexo), 32'h0);
      wait_t(32); chk("lit_ack_commit", 32'(load_ack), 32'h1);
      chk("lit_hexo_d0", 32'(hexo), 32'h1);
      wait_t(44); chk("lit_hexo_d3", 32'(hexo), 32'h4);

      // two loads in one frame: last wins
      do_load(16'hAAAA, 4'h0, 4'h0, 4'h0, 4'h0);
      wait_t(45); do_load(16'h5555, 4'h0, 4'h0, 4'h0, 4'h0);
      wait_t(52); chk("lit_last_wins", 32'(hexo), 32'h5);

      // load on the wrapping tick
      wait_t(63); do_load(16'h00F0, 4'h0, 4'h0, 4'h0, 4'h0);
      chk("lit_direct_ack", 32'(load_ack), 32'h1);
      wait_t(68); chk("lit_direct_hexo", 32'(hexo), 32'hF);

      // blanked digit 2 with point/le pattern
      wait_t(70); do_load(16'h4321, 4'b0101, 4'b1010, 4'b0100, 4'h0);
      wait_t(89); chk("lit_blank_an", 32'(an), 32'hF);
      chk("lit_blank_hexo", 32'(hexo), 32'h3);
      chk("lit_blank_p", 32'(p), 32'h1);

      // pending load then asynchronous reset mid-slot
      wait_t(98); do_load(16'h9999, 4'h0, 4'h0, 4'h0, 4'h0);
      wait_t(101);
      #2 rst_n = 1'b0;
      #1;
      chk("lit_async_an", 32'(an), 32'hF);
      chk("lit_async_scan", 32'(scan), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst_n = 1'b1;
      wait_t(16); chk("lit_discard_ack", 32'(load_ack), 32'h0);
      wait_t(20); chk("lit_discard_hexo", 32'(hexo), 32'h0);

      // blink digit 0, committed at the start of frame 2
      do_load(16'h8765, 4'h0, 4'h0, 4'h0, 4'b0001);
      wait_t(33); chk("lit_blink_f2", 32'(an), BLINK_ON ? 32'hF : 32'hE);
      wait_t(36); chk("lit_blink_hexo", 32'(hexo), 32'h6);
      wait_t(65); chk("lit_blink_f4", 32'(an), 32'hE);
      wait_t(97); chk("lit_blink_f6", 32'(an), BLINK_ON ? 32'hF : 32'hE);
      wait_t(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
